camera_capture_s_axi_regs: RTL and testbench
============================================

CAMERA_CAPTURE_S_AXI_REGS -- requirements
Module: camera_capture_s_axi_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 6, byte-address width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset (fixed polarity and synchronicity).
REQ-004 ACLK  in  1  sole clock, all logic rising-edge.
REQ-005 ARESET  in  1  asynchronous active-high reset.
REQ-006 S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
REQ-007 S_AXI_AWPROT  in  3  ignored.
REQ-008 S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
REQ-009 S_AXI_WDATA  in  32  write data.
REQ-010 S_AXI_WSTRB  in  4  byte enables, bit n gates WDATA[8n+7:8n].
REQ-011 S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
REQ-012 S_AXI_BRESP  out  2  write response, 2'b00 OKAY, 2'b10 SLVERR.
REQ-013 S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
REQ-014 S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address; S_AXI_ARPROT in 3 ignored.
REQ-015 S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
REQ-016 S_AXI_RDATA  out  32  read data; S_AXI_RRESP out 2 read response.
REQ-017 S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
REQ-018 REG0_OUT..REG3_OUT  out  32 each  current register contents to capture logic.

Function
REQ-019 SHALL decode word index = ADDR[C_S_AXI_ADDR_WIDTH-1:2]; indices 0-3 map to REG0-REG3 (byte offsets 0x0,0x4,0x8,0xC); ADDR[1:0] ignored.
REQ-020 SHALL treat indices 4 and above as unmapped: writes change nothing and return SLVERR; reads return RDATA 0 with SLVERR.
REQ-021 SHALL accept AW and W independently, in either order or same cycle, latching each; AWREADY = no address held and BVALID low; WREADY = no data held and BVALID low.
REQ-022 SHALL commit the write on the first edge where both address and data are held (or arrive that edge), applying WSTRB per byte, and assert BVALID the following cycle.
REQ-023 Write FSM states: W_IDLE (collecting AW/W) -> W_RESP (BVALID high) on commit; W_RESP -> W_IDLE on BVALID&&BREADY, clearing both latches.
REQ-024 Minimum write latency: AW and W in cycle N -> register updated and BVALID high in cycle N+1.
REQ-025 BVALID and BRESP SHALL hold stable until BREADY; no further AW/W accepted meanwhile (one outstanding write).
REQ-026 Read: ARREADY = !RVALID; on ARVALID&&ARREADY in cycle N, RDATA/RRESP registered, RVALID high cycle N+1.
REQ-027 RVALID, RDATA, RRESP SHALL hold stable until RREADY; RVALID clears the cycle after RVALID&&RREADY (one outstanding read).
REQ-028 Simultaneous write commit and read capture of the same register: read returns the pre-write value.
REQ-029 Read and write channels SHALL operate concurrently without mutual stalling.
REQ-030 REGn_OUT SHALL reflect register contents combinationally from the registers (no extra delay after commit).

Reset
REQ-031 On ARESET high, asynchronously: REG0-REG3 = 0, AWREADY/WREADY/ARREADY = 0, BVALID/RVALID = 0, BRESP/RRESP = 2'b00, RDATA = 0, latches cleared, FSM W_IDLE.
REQ-032 READY outputs SHALL rise no earlier than the first ACLK edge after ARESET deasserts.
REQ-033 Reset mid-transaction SHALL abandon it: no response issued after reset, no partial register update.

Verification
REQ-034 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC (WSTRB 0xF), read back -> RDATA 0x1..0x4, all BRESP/RRESP OKAY.
REQ-035 REG1=0xAABBCCDD, write 0x11223344 with WSTRB 0x5 -> REG1 reads 0xAA22CC44.
REQ-036 WVALID 3 cycles before AWVALID, address 0x8 -> WREADY accepts first, one BVALID after AW handshake, REG2 updated once.
REQ-037 BREADY held low 5 cycles -> BVALID/BRESP stable, AWREADY and WREADY low throughout; same for RREADY on reads.
REQ-038 Write 0xDEAD to 0x10, read 0x14 -> BRESP 2'b10, RRESP 2'b10, RDATA 0, REG0-REG3 unchanged.
REQ-039 ARESET pulsed while BVALID high -> BVALID 0 immediately, all REGn_OUT 0, next write completes normally.

Source files
------------

// File: rtl/camera_capture_s_axi_regs.sv
// camera_capture_s_axi_regs
//   AXI4-Lite slave exposing four 32-bit control registers to the camera
//   capture logic. One outstanding write and one outstanding read; the two
//   channels run independently of each other.
//
// Ports
//   ACLK, ARESET            clock, asynchronous active-high reset
//   S_AXI_AW*               write address channel (AWPROT ignored)
//   S_AXI_W*                write data channel, WSTRB byte enables
//   S_AXI_B*                write response (OKAY / SLVERR)
//   S_AXI_AR*               read address channel (ARPROT ignored)
//   S_AXI_R*                read data / response
//   REG0_OUT..REG3_OUT      live register contents
module camera_capture_s_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            ACLK,
    input  logic                            ARESET,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,

    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,

    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,

    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,

    output logic [C_S_AXI_DATA_WIDTH-1:0]   REG0_OUT,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   REG1_OUT,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   REG2_OUT,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   REG3_OUT
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int AW     = C_S_AXI_ADDR_WIDTH;
    localparam int IDX_W  = AW - 2;
    localparam int STRB_W = DW / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    wr_state_t wr_state, wr_state_nxt;

    // Readies stay low until the first clock edge after reset release.
    logic ready_en;

    logic              aw_held;
    logic [IDX_W-1:0]  aw_idx_q;
    logic              w_held;
    logic [DW-1:0]     w_data_q;
    logic [STRB_W-1:0] w_strb_q;

    logic [DW-1:0]     regs [4];
    logic [1:0]        bresp_q;

    logic              rvalid_q;
    logic [DW-1:0]     rdata_q;
    logic [1:0]        rresp_q;

    logic              aw_fire, w_fire, ar_fire, b_fire;
    logic              commit;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic [DW-1:0]     wr_data, wr_mask;
    logic [STRB_W-1:0] wr_strb;
    logic              wr_mapped, rd_mapped;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign S_AXI_AWREADY = ready_en && !aw_held && (wr_state == W_IDLE);
    assign S_AXI_WREADY  = ready_en && !w_held  && (wr_state == W_IDLE);
    assign S_AXI_BVALID  = (wr_state == W_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = ready_en && !rvalid_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    assign aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_fire  = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;
    assign b_fire  = S_AXI_BVALID  && S_AXI_BREADY;

    // Address and data may each come from the latch or straight off the
    // bus, so a same-cycle AW+W commits on the edge it arrives.
    assign wr_idx  = aw_held ? aw_idx_q : S_AXI_AWADDR[AW-1:2];
    assign wr_data = w_held  ? w_data_q : S_AXI_WDATA;
    assign wr_strb = w_held  ? w_strb_q : S_AXI_WSTRB;
    assign commit  = (wr_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);

    assign rd_idx  = S_AXI_ARADDR[AW-1:2];

    // Only word indices 0..3 are backed by registers.
    assign wr_mapped = ((wr_idx >> 2) == '0);
    assign rd_mapped = ((rd_idx >> 2) == '0);

    for (genvar g = 0; g < STRB_W; g++) begin : g_mask
        assign wr_mask[8*g +: 8] = {8{wr_strb[g]}};
    end

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state <= W_IDLE;
        end else begin
            wr_state <= wr_state_nxt;
        end
    end

    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            W_IDLE:  if (commit) wr_state_nxt = W_RESP;
            W_RESP:  if (b_fire) wr_state_nxt = W_IDLE;
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Write channel latches, response and register file
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ready_en <= 1'b0;
            aw_held  <= 1'b0;
            aw_idx_q <= '0;
            w_held   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bresp_q  <= RESP_OKAY;
            regs     <= '{default: '0};
        end else begin
            ready_en <= 1'b1;

            if (b_fire) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_fire) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= S_AXI_AWADDR[AW-1:2];
                end
                if (w_fire) begin
                    w_held   <= 1'b1;
                    w_data_q <= S_AXI_WDATA;
                    w_strb_q <= S_AXI_WSTRB;
                end
            end

            if (commit) begin
                bresp_q <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
                if (wr_mapped) begin
                    regs[wr_idx[1:0]] <= (regs[wr_idx[1:0]] & ~wr_mask) | (wr_data & wr_mask);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel. The read samples regs before this edge's write lands,
    // so a same-edge read of the written register returns the old value.
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_fire) begin
            rvalid_q <= 1'b1;
            if (rd_mapped) begin
                rdata_q <= regs[rd_idx[1:0]];
                rresp_q <= RESP_OKAY;
            end else begin
                rdata_q <= '0;
                rresp_q <= RESP_SLVERR;
            end
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    assign REG0_OUT = regs[0];
    assign REG1_OUT = regs[1];
    assign REG2_OUT = regs[2];
    assign REG3_OUT = regs[3];

    // Protection bits and byte-offset bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_camera_capture_s_axi_regs.sv
// tb_camera_capture_s_axi_regs
//   Directed, self-checking bench for camera_capture_s_axi_regs. Inputs are
//   driven 1 time unit after the rising edge, outputs sampled on the falling
//   edge; expected values are hand-computed constants.
module tb_camera_capture_s_axi_regs;

    logic        ACLK;
    logic        ARESET;
    logic [5:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [5:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [31:0] REG0_OUT, REG1_OUT, REG2_OUT, REG3_OUT;

    int checks = 0;
    int errors = 0;

    camera_capture_s_axi_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(6)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .REG0_OUT      (REG0_OUT),
        .REG1_OUT      (REG1_OUT),
        .REG2_OUT      (REG2_OUT),
        .REG3_OUT      (REG3_OUT)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
        check({tag, "_reg0"}, REG0_OUT, e0);
        check({tag, "_reg1"}, REG1_OUT, e1);
        check({tag, "_reg2"}, REG2_OUT, e2);
        check({tag, "_reg3"}, REG3_OUT, e3);
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int   n;
        logic aw_go, w_go;
        S_AXI_AWADDR  = a;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = d;
        S_AXI_WSTRB   = s;
        S_AXI_WVALID  = 1'b1;
        S_AXI_BREADY  = 1'b1;
        n = 0;
        while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 20) begin
            @(negedge ACLK);
            aw_go = S_AXI_AWVALID && S_AXI_AWREADY;
            w_go  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge ACLK); #1;
            if (aw_go) S_AXI_AWVALID = 1'b0;
            if (w_go)  S_AXI_WVALID  = 1'b0;
            n++;
        end
        check("wr_accept", {30'd0, S_AXI_AWVALID, S_AXI_WVALID}, 32'd0);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        @(negedge ACLK);
        check("wr_bvalid_latency", {31'd0, S_AXI_BVALID}, 32'd1);
        resp = S_AXI_BRESP;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
        int   n;
        logic go;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b1;
        n = 0;
        while (S_AXI_ARVALID && n < 20) begin
            @(negedge ACLK);
            go = S_AXI_ARVALID && S_AXI_ARREADY;
            @(posedge ACLK); #1;
            if (go) S_AXI_ARVALID = 1'b0;
            n++;
        end
        check("rd_accept", {31'd0, S_AXI_ARVALID}, 32'd0);
        S_AXI_ARVALID = 1'b0;
        @(negedge ACLK);
        check("rd_rvalid_latency", {31'd0, S_AXI_RVALID}, 32'd1);
        d    = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    logic [1:0]  resp;
    logic [31:0] rd;

    initial begin
        ARESET        = 1'b1;
        S_AXI_AWADDR  = '0;
        S_AXI_AWPROT  = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_ARADDR  = '0;
        S_AXI_ARPROT  = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;

        // ---------------- reset state ----------------
        #12;
        check("rst_readies", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd0);
        check("rst_valids", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'd0);
        check("rst_resps", {28'd0, S_AXI_BRESP, S_AXI_RRESP}, 32'd0);
        check("rst_rdata", S_AXI_RDATA, 32'd0);
        check_regs("rst", 32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        check("rel_readies_before_edge", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd0);
        @(posedge ACLK); #1;
        check("rel_readies_after_edge", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd7);

        // ---------------- basic write / read of all four ----------------
        for (int i = 0; i < 4; i++) begin
            axi_write(6'(4 * i), 32'(i + 1), 4'hF, resp);
            check($sformatf("basic_bresp%0d", i), {30'd0, resp}, 32'd0);
        end
        check_regs("basic", 32'd1, 32'd2, 32'd3, 32'd4);
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(4 * i), rd, resp);
            check($sformatf("basic_rdata%0d", i), rd, 32'(i + 1));
            check($sformatf("basic_rresp%0d", i), {30'd0, resp}, 32'd0);
        end

        // ---------------- same-edge write and read of REG3 ----------------
        S_AXI_AWADDR  = 6'h0C;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = 32'hCAFE_0003;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_WVALID  = 1'b1;
        S_AXI_BREADY  = 1'b1;
        S_AXI_ARADDR  = 6'h0C;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b1;
        @(negedge ACLK);
        check("rw_readies", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd7);
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        @(negedge ACLK);
        check("rw_valids", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'd3);
        check("rw_rdata_old", S_AXI_RDATA, 32'd4);
        check("rw_reg3_new", REG3_OUT, 32'hCAFE_0003);
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        @(negedge ACLK);
        check("rw_valids_clear", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'd0);
        @(posedge ACLK); #1;

        // ---------------- byte strobes ----------------
        axi_write(6'h04, 32'hAABB_CCDD, 4'hF, resp);
        axi_write(6'h04, 32'h1122_3344, 4'h5, resp);
        check("strb_bresp", {30'd0, resp}, 32'd0);
        axi_read(6'h04, rd, resp);
        check("strb_rdata", rd, 32'hAA22_CC44);

        // ---------------- W three cycles ahead of AW ----------------
        S_AXI_WDATA  = 32'h5A5A_0008;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        check("wfirst_wready", {31'd0, S_AXI_WREADY}, 32'd1);
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check($sformatf("wfirst_wait%0d", i), {29'd0, S_AXI_BVALID, S_AXI_WREADY, S_AXI_AWREADY}, 32'd1);
            check($sformatf("wfirst_reg2_old%0d", i), REG2_OUT, 32'd3);
        end
        @(posedge ACLK); #1;
        S_AXI_AWADDR  = 6'h08;
        S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        check("wfirst_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        @(negedge ACLK);
        check("wfirst_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
        check("wfirst_bresp", {30'd0, S_AXI_BRESP}, 32'd0);
        check("wfirst_reg2_new", REG2_OUT, 32'h5A5A_0008);
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge ACLK);
            check($sformatf("wfirst_single_b%0d", i), {31'd0, S_AXI_BVALID}, 32'd0);
        end
        @(posedge ACLK); #1;

        // ---------------- BREADY stall (unmapped, SLVERR held) ----------------
        S_AXI_AWADDR  = 6'h18;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = 32'h1234_5678;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_WVALID  = 1'b1;
        S_AXI_BREADY  = 1'b0;
        @(negedge ACLK);
        check("bstall_readies", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 32'd3);
        @(posedge ACLK); #1;
        // Offer a second write that must not be taken while the response waits.
        S_AXI_AWADDR = 6'h00;
        S_AXI_WDATA  = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check($sformatf("bstall_hold%0d", i),
                  {28'd0, S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY | S_AXI_WREADY}, {28'd0, 4'b1100});
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        @(negedge ACLK);
        check("bstall_released", {31'd0, S_AXI_BVALID}, 32'd0);
        check("bstall_reg0", REG0_OUT, 32'd1);
        @(posedge ACLK); #1;

        // ---------------- RREADY stall ----------------
        S_AXI_ARADDR  = 6'h04;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b0;
        @(negedge ACLK);
        check("rstall_arready", {31'd0, S_AXI_ARREADY}, 32'd1);
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check($sformatf("rstall_ctl%0d", i),
                  {28'd0, S_AXI_RVALID, S_AXI_RRESP, S_AXI_ARREADY}, {28'd0, 4'b1000});
            check($sformatf("rstall_data%0d", i), S_AXI_RDATA, 32'hAA22_CC44);
        end
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
        @(negedge ACLK);
        check("rstall_released", {31'd0, S_AXI_RVALID}, 32'd0);
        @(posedge ACLK); #1;

        // ---------------- unmapped accesses, byte offset ignored ----------------
        axi_write(6'h10, 32'h0000_DEAD, 4'hF, resp);
        check("unmap_bresp", {30'd0, resp}, 32'd2);
        axi_read(6'h14, rd, resp);
        check("unmap_rdata", rd, 32'd0);
        check("unmap_rresp", {30'd0, resp}, 32'd2);
        check_regs("unmap", 32'd1, 32'hAA22_CC44, 32'h5A5A_0008, 32'hCAFE_0003);
        axi_read(6'h07, rd, resp);
        check("offset_rdata", rd, 32'hAA22_CC44);

        // ---------------- reset while BVALID high ----------------
        S_AXI_AWADDR  = 6'h00;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = 32'h0000_0099;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_WVALID  = 1'b1;
        S_AXI_BREADY  = 1'b0;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        @(negedge ACLK);
        check("arst_pre_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
        #2;
        ARESET = 1'b1;
        #1;
        check("arst_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
        check("arst_readies", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd0);
        check_regs("arst", 32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge ACLK);
        ARESET       = 1'b0;
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        @(negedge ACLK);
        check("arst_no_resp", {31'd0, S_AXI_BVALID}, 32'd0);
        S_AXI_BREADY = 1'b0;
        @(posedge ACLK); #1;
        axi_write(6'h00, 32'h0000_0077, 4'hF, resp);
        check("arst_after_bresp", {30'd0, resp}, 32'd0);
        check_regs("arst_after", 32'h77, 32'd0, 32'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
